tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Game-speed controller that drives the terminal count N of the pulse divider and consumes its Pulse output. It sequences a play session through speed levels, shrinking N as play advances. It handles pause and stop, and distributes each divider pulse round-robin to four game subsystems as one-cycle Tick strobes. It sits between the top-level game FSM (Start/Pause/Stop) and the pulse divider and subsystem logic.

## Interface
- WIDTH, 28: width of N; must match the divider's WIDTH.
- BASE_N, 50000000: N at level 0.
- STEP, 5000000: N decrement per level.
- MIN_N, 5000000: floor for N. Must satisfy BASE_N >= MIN_N >= 2.
- TICKS_PER_LEVEL, 32: pulses per level. Must be >= 1.
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  level; begins a fresh session from IDLE or FINISH.
- Pause  in  1  level; while high in RUN/PAUSED, play is held.
- Stop  in  1  level; aborts to IDLE from any state.
- Pulse  in  1  one-cycle strobe from the pulse divider.
- N  out  WIDTH  terminal count to the divider; 0 disables it.
- Tick  out  4  one-hot per-subsystem strobe, one cycle wide.
- Level  out  3  current speed level, 0..7.
- Running  out  1  high in RUN only.
- Done  out  1  high in FINISH only.

## Operation
- States: IDLE, RUN, PAUSED, FINISH. Input priority every cycle: Stop > Start > Pause > Pulse.
- Reset (Reset=0): state IDLE. N=0, Tick=0, Level=0, Running=0, Done=0, tick counter=0, client pointer=0. Takes effect immediately, including mid-session.
- IDLE: N=0 and Pulse is ignored.
  - Start=1 -> RUN with Level=0, N=BASE_N, counter=0, pointer=0.
- RUN, Pulse=1 and no higher-priority input:
  - Tick[pointer] asserts next cycle; pointer = (pointer+1) mod 4.
  - Counter increments. When the counter is at TICKS_PER_LEVEL-1, it wraps to 0 and the level ends.
  - At level end with Level<7: Level+1, and N = max(BASE_N - STEP*(Level+1), MIN_N).
  - At level end with Level==7: -> FINISH.
- RUN, Pause=1 -> PAUSED. N=0, which stops the divider. Counter, pointer and Level are held.
- PAUSED: Pulse is ignored. Pause=0 -> RUN, and N is restored to the level value recomputed from Level.
- FINISH: N=0, Done=1, Level holds 7, Pulse is ignored.
  - Start=1 -> RUN as from IDLE.
  - Stop=1 -> IDLE.
- Stop=1 in any state -> IDLE. N=0, Level=0, counter=0, pointer=0. No Tick is issued for a Pulse in the same cycle.
- Start while in RUN or PAUSED: ignored.
- Pause together with Pulse in RUN: the Pulse is dropped (no Tick, no count) and the state goes to PAUSED.
- Arithmetic: compute BASE_N - STEP*L in WIDTH+4 bits, signed-safe. Any result below MIN_N, including negative, saturates to MIN_N. N is always 0 or within [MIN_N, BASE_N].

## Timing
- All outputs are registered. N, Level, Running and Done change on the edge after the triggering input is sampled.
- Tick latency: Pulse sampled high at edge k gives a Tick high for exactly the cycle after edge k. At most one Tick bit is high at any time.
- A level change updates N on the same edge as Level. The divider restarts its count on any N change; this block adds no further delay.
- Back-to-back Pulses on consecutive cycles each produce a Tick, rotating the client.
- Pause release: N becomes nonzero one cycle after Pause falls. The first post-resume Pulse occurs after one full divider period.

## Test plan
Bench parameters: BASE_N=10, STEP=2, MIN_N=4, TICKS_PER_LEVEL=4. The bench is connected to a behavioural divider.

- Reset, then idle: Reset=0 for 3 cycles, then Reset=1 with no Start -> N=0, Tick=0, Level=0, Running=0, Done=0. Forced Pulse strobes produce no Tick.
- Full session: Start one cycle -> N=10. N steps 10,8,6,4,4,4,4,4 every 4 Pulses. Tick order is 0001,0010,0100,1000 repeating. After the 32nd Pulse, Done=1 and N=0.
- Pause collision: in RUN at Level 1, assert Pause and Pulse together -> no Tick and counter unchanged. N=0 next cycle. Release Pause -> N=8, and the pointer resumes at the held client.
- Stop priority: Stop, Start and Pulse all high in RUN at Level 3 -> IDLE, N=0, Level=0, no Tick.
- Async reset mid-level: drop Reset between edges during RUN at Level 2 -> all outputs 0 before the next edge. After release, the state is IDLE.
- FINISH restart: from FINISH assert Start -> Done=0, Running=1, N=10, Level=0, first Tick on bit 0.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// Control/status bundle between the game FSM, the pulse divider and tick_scheduler.
// Pulse comes from the divider, N goes back to it; the rest is game-level control and status.
interface tick_scheduler_if #(
    parameter int WIDTH = 28
);
    logic             Start;
    logic             Pause;
    logic             Stop;
    logic             Pulse;
    logic [WIDTH-1:0] N;
    logic [3:0]       Tick;
    logic [2:0]       Level;
    logic             Running;
    logic             Done;

    modport master (
        output Start, Pause, Stop, Pulse,
        input  N, Tick, Level, Running, Done
    );

    modport slave (
        input  Start, Pause, Stop, Pulse,
        output N, Tick, Level, Running, Done
    );
endinterface

// File: rtl/tick_scheduler.sv
// Speed-level sequencer: shrinks divider count N per level and fans Pulse out round-robin as Tick.
// All outputs registered, one-cycle latency; no backpressure, Pulse is dropped outside RUN.
module tick_scheduler #(
    parameter int WIDTH           = 28,
    parameter int BASE_N          = 50000000,
    parameter int STEP            = 5000000,
    parameter int MIN_N           = 5000000,
    parameter int TICKS_PER_LEVEL = 32
) (
    input logic             Clk,
    input logic             Reset,
    tick_scheduler_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam int CW = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_LEVEL - 1);

    localparam logic signed [WIDTH+3:0] BASE_S = (WIDTH+4)'(BASE_N);
    localparam logic signed [WIDTH+3:0] STEP_S = (WIDTH+4)'(STEP);
    localparam logic signed [WIDTH+3:0] MIN_S  = (WIDTH+4)'(MIN_N);

    logic [1:0]       state;
    logic [WIDTH-1:0] n_q;
    logic [3:0]       tick_q;
    logic [2:0]       level_q;
    logic [CW-1:0]    cnt;
    logic [1:0]       ptr;
    logic             running_q;
    logic             done_q;

    // Extra headroom bits keep BASE_N - STEP*L from wrapping; negatives clamp to the floor.
    function automatic logic [WIDTH-1:0] level_n(input logic [2:0] lvl);
        logic signed [WIDTH+3:0] v;
        v = BASE_S - STEP_S * $signed({{(WIDTH+1){1'b0}}, lvl});
        if (v < MIN_S) level_n = WIDTH'(MIN_N);
        else           level_n = v[WIDTH-1:0];
    endfunction

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            n_q       <= '0;
            tick_q    <= '0;
            level_q   <= '0;
            cnt       <= '0;
            ptr       <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tick_q <= '0;
            if (bus.Stop) begin
                state     <= S_IDLE;
                n_q       <= '0;
                level_q   <= '0;
                cnt       <= '0;
                ptr       <= '0;
                running_q <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_FINISH: begin
                        if (bus.Start) begin
                            state     <= S_RUN;
                            n_q       <= WIDTH'(BASE_N);
                            level_q   <= '0;
                            cnt       <= '0;
                            ptr       <= '0;
                            running_q <= 1'b1;
                            done_q    <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        // Pause outranks Pulse, so a colliding Pulse is lost entirely.
                        if (bus.Pause) begin
                            state     <= S_PAUSED;
                            n_q       <= '0;
                            running_q <= 1'b0;
                        end else if (bus.Pulse) begin
                            tick_q <= 4'b0001 << ptr;
                            ptr    <= ptr + 2'd1;
                            if (cnt == CNT_LAST) begin
                                cnt <= '0;
                                if (level_q == 3'd7) begin
                                    state     <= S_FINISH;
                                    n_q       <= '0;
                                    running_q <= 1'b0;
                                    done_q    <= 1'b1;
                                end else begin
                                    level_q <= level_q + 3'd1;
                                    n_q     <= level_n(level_q + 3'd1);
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (!bus.Pause) begin
                            state     <= S_RUN;
                            n_q       <= level_n(level_q);
                            running_q <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.N       = n_q;
    assign bus.Tick    = tick_q;
    assign bus.Level   = level_q;
    assign bus.Running = running_q;
    assign bus.Done    = done_q;
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with a small behavioural pulse divider on N.
module tb_tick_scheduler;
    localparam int W = 28;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic force_pulse = 1'b0;
    logic div_en = 1'b0;
    logic div_pulse;
    logic [W-1:0] dcnt, nprev;
    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    tick_scheduler_if #(.WIDTH(W)) bus ();

    tick_scheduler #(
        .WIDTH(W), .BASE_N(10), .STEP(2), .MIN_N(4), .TICKS_PER_LEVEL(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus)
    );

    // Divider: one-cycle pulse every N cycles, restarting whenever N changes.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dcnt      <= '0;
            nprev     <= '0;
            div_pulse <= 1'b0;
        end else begin
            nprev     <= bus.N;
            div_pulse <= 1'b0;
            if (bus.N == '0 || bus.N != nprev) dcnt <= '0;
            else if (dcnt == bus.N - 1) begin
                dcnt      <= '0;
                div_pulse <= 1'b1;
            end else dcnt <= dcnt + 1'b1;
        end
    end

    assign bus.Pulse = force_pulse | (div_en & div_pulse);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse1();
        force_pulse = 1'b1;
        cyc();
        force_pulse = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_n"}, bus.N, 0);
        check({tag, "_tick"}, bus.Tick, 0);
        check({tag, "_level"}, bus.Level, 0);
        check({tag, "_running"}, bus.Running, 0);
        check({tag, "_done"}, bus.Done, 0);
    endtask

    int nexp[8] = '{10, 8, 6, 4, 4, 4, 4, 4};

    initial begin
        int t;
        logic [3:0] oh;
        bus.Start = 1'b0;
        bus.Pause = 1'b0;
        bus.Stop  = 1'b0;

        // Reset, then idle with forced pulses
        repeat (3) cyc();
        check_all_zero("in_reset");
        Reset = 1'b1;
        cyc();
        check_all_zero("idle");
        force_pulse = 1'b1;
        cyc();
        cyc();
        force_pulse = 1'b0;
        check("idle_pulse_tick", bus.Tick, 0);
        check("idle_pulse_n", bus.N, 0);

        // Full session driven by the divider
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        check("start_n", bus.N, 10);
        check("start_running", bus.Running, 1);
        check("start_level", bus.Level, 0);
        div_en = 1'b1;
        t = 0;
        for (int c = 0; c < 1500 && t < 32; c++) begin
            cyc();
            if (bus.Tick != 4'b0000) begin
                t++;
                oh = 4'b0001 << ((t - 1) % 4);
                check("sess_tick", bus.Tick, oh);
                if (t < 32) begin
                    check("sess_n", bus.N, nexp[t / 4]);
                    check("sess_level", bus.Level, t / 4);
                end else begin
                    check("fin_done", bus.Done, 1);
                    check("fin_n", bus.N, 0);
                    check("fin_running", bus.Running, 0);
                    check("fin_level", bus.Level, 7);
                end
            end
        end
        check("sess_tick_count", t, 32);
        div_en = 1'b0;
        cyc();
        check("fin_hold_done", bus.Done, 1);
        force_pulse = 1'b1;
        cyc();
        force_pulse = 1'b0;
        check("fin_pulse_ignored", bus.Tick, 0);

        // FINISH restart
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        check("restart_done", bus.Done, 0);
        check("restart_running", bus.Running, 1);
        check("restart_n", bus.N, 10);
        check("restart_level", bus.Level, 0);
        pulse1();
        check("restart_tick0", bus.Tick, 4'b0001);

        // Advance to Level 1, counter=1, pointer=1
        repeat (3) pulse1();
        check("lvl1_n", bus.N, 8);
        check("lvl1_level", bus.Level, 1);
        pulse1();
        check("lvl1_tick", bus.Tick, 4'b0001);

        // Pause collision
        bus.Pause = 1'b1;
        force_pulse = 1'b1;
        cyc();
        check("collide_tick", bus.Tick, 0);
        check("collide_n", bus.N, 0);
        check("collide_running", bus.Running, 0);
        cyc();
        force_pulse = 1'b0;
        check("paused_pulse_tick", bus.Tick, 0);
        check("paused_level", bus.Level, 1);
        bus.Pause = 1'b0;
        cyc();
        check("resume_n", bus.N, 8);
        check("resume_running", bus.Running, 1);
        pulse1();
        check("resume_tick", bus.Tick, 4'b0010);
        pulse1();
        check("resume_tick2", bus.Tick, 4'b0100);
        check("count_held_level", bus.Level, 1);
        pulse1();
        check("lvl2_tick", bus.Tick, 4'b1000);
        check("lvl2_level", bus.Level, 2);
        check("lvl2_n", bus.N, 6);

        // Async reset between edges at Level 2
        pulse1();
        #3;
        Reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        cyc();
        Reset = 1'b1;
        cyc();
        check_all_zero("post_rst_idle");
        pulse1();
        check("post_rst_pulse", bus.Tick, 0);

        // Stop priority at Level 3, back-to-back pulses to get there
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        force_pulse = 1'b1;
        repeat (12) cyc();
        force_pulse = 1'b0;
        check("lvl3_level", bus.Level, 3);
        check("lvl3_n", bus.N, 4);
        check("lvl3_tick", bus.Tick, 4'b1000);
        bus.Stop = 1'b1;
        bus.Start = 1'b1;
        force_pulse = 1'b1;
        cyc();
        bus.Stop = 1'b0;
        bus.Start = 1'b0;
        force_pulse = 1'b0;
        check_all_zero("stop_prio");
        pulse1();
        check("stop_idle_tick", bus.Tick, 0);
        check("stop_idle_n", bus.N, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
